// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (I), core load/store (D)
//   and the accelerator DMA (A). Fixed priority D > I > A; A is promoted to
//   top priority after STARVE_LIMIT lost arbitrations. One transaction is in
//   flight at a time: IDLE (arbitrate) -> BUSY (wait mem_ready or timeout)
//   -> RESP (one-cycle done pulse) -> IDLE.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_req/i_addr                 fetch request (read only)
//   d_req/d_we/d_addr/d_wdata    load/store request
//   a_req/a_we/a_addr/a_wdata    DMA request
//   *_rdata, *_done              per-requester read data and completion pulse
//   err                          high with the done pulse of an aborted access
//   mem_valid/we/addr/wdata      memory request, held stable while busy
//   mem_rdata, mem_ready         memory response
//   owner                        0 none, 1 I, 2 D, 3 A
//   busy                         transaction in progress
module mem_port_arbiter #(
  parameter int unsigned AW           = 19,
  parameter int unsigned DW           = 19,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_done,
  output logic          err,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [1:0]    owner,
  output logic          busy
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D, OWN_A} own_t;

  state_t        state_q,     state_d;
  own_t          owner_q,     owner_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] i_rdata_q,   i_rdata_d;
  logic [DW-1:0] d_rdata_q,   d_rdata_d;
  logic [DW-1:0] a_rdata_q,   a_rdata_d;
  logic          abort_q,     abort_d;
  logic [SW-1:0] starve_q,    starve_d;
  logic [TW-1:0] tmo_q,       tmo_d;
  own_t          grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      a_rdata_q   <= '0;
      abort_q     <= 1'b0;
      starve_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      a_rdata_q   <= a_rdata_d;
      abort_q     <= abort_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    a_rdata_d   = a_rdata_q;
    abort_d     = abort_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    grant       = OWN_NONE;

    // A starved for STARVE_LIMIT arbitrations overrides the fixed order.
    if (a_req && (starve_q == SW'(STARVE_LIMIT))) grant = OWN_A;
    else if (d_req)                               grant = OWN_D;
    else if (i_req)                               grant = OWN_I;
    else if (a_req)                               grant = OWN_A;

    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (grant != OWN_NONE) begin
          state_d     = BUSY;
          owner_d     = grant;
          mem_valid_d = 1'b1;
          abort_d     = 1'b0;
          unique case (grant)
            OWN_D: begin
              mem_we_d    = d_we;
              mem_addr_d  = d_addr;
              mem_wdata_d = d_wdata;
            end
            OWN_A: begin
              mem_we_d    = a_we;
              mem_addr_d  = a_addr;
              mem_wdata_d = a_wdata;
            end
            default: begin
              mem_we_d    = 1'b0;
              mem_addr_d  = i_addr;
              mem_wdata_d = '0;
            end
          endcase
          if (grant == OWN_A)
            starve_d = '0;
          else if (a_req && (starve_q != SW'(STARVE_LIMIT)))
            starve_d = starve_q + 1'b1;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = RESP;
          if (!mem_we_q) begin
            unique case (owner_q)
              OWN_I:   i_rdata_d = mem_rdata;
              OWN_D:   d_rdata_d = mem_rdata;
              OWN_A:   a_rdata_d = mem_rdata;
              default: ;
            endcase
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TW'(TIMEOUT - 1)) begin
            mem_valid_d = 1'b0;
            abort_d     = 1'b1;
            state_d     = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
        tmo_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Done/err are decoded from the RESP state so they last exactly one cycle.
  assign i_done    = (state_q == RESP) && (owner_q == OWN_I);
  assign d_done    = (state_q == RESP) && (owner_q == OWN_D);
  assign a_done    = (state_q == RESP) && (owner_q == OWN_A);
  assign err       = (state_q == RESP) && abort_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign a_rdata   = a_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, a_req = 1'b0;
  logic        d_we = 1'b0, a_we = 1'b0;
  logic [18:0] i_addr = '0, d_addr = '0, a_addr = '0;
  logic [18:0] d_wdata = '0, a_wdata = '0;
  logic [18:0] i_rdata, d_rdata, a_rdata;
  logic        i_done, d_done, a_done, err;
  logic        mem_valid, mem_we, mem_ready = 1'b0;
  logic [18:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [1:0]  owner;
  logic        busy;

  mem_port_arbiter #(.AW(19), .DW(19), .STARVE_LIMIT(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_done(a_done),
    .err(err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] rd;
    logic        err;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } dchk_t;

  typedef struct {
    logic [1:0]  own;
    logic        we;
    logic [18:0] addr;
    logic [18:0] wd;
    int          cyc;
  } g_t;

  exp_t  qi[$], qd[$], qa[$];
  dchk_t dq[$];
  g_t    glog[$];
  logic [18:0] last_rd [1:3];
  int    pass_cnt = 0, total_cnt = 0;
  int    cyc = 0;
  int    wait_cycles = 0;
  int    wcnt = 0;
  logic  prev_mv = 1'b0;

  // Memory contents seen by the responder.
  function automatic logic [18:0] mem_fn(input logic [18:0] a);
    if (a == 19'h00010) return 19'h1ABCD;
    return a ^ 19'h2C3C3;
  endfunction

  // Memory responder: mem_ready after wait_cycles BUSY cycles; -1 = never.
  always @(negedge clk) begin
    if (!mem_valid) begin
      wcnt      = 0;
      mem_ready = 1'b0;
    end else begin
      mem_ready = (wait_cycles >= 0) && (wcnt == wait_cycles);
      wcnt++;
    end
    mem_rdata = mem_fn(mem_addr);
  end

  task automatic cmp_done(input string who, input bit have, input exp_t e,
                          input logic [18:0] rd);
    total_cnt++;
    if (!have) begin
      $display("FAIL %s_done: got unexpected done pulse, required none", who);
    end else if (rd !== e.rd || err !== e.err) begin
      $display("FAIL %s_resp: got rdata=%05h err=%0b, required rdata=%05h err=%0b",
               who, rd, err, e.rd, e.err);
    end else begin
      pass_cnt++;
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse, then drains direct checks.
  always @(negedge clk) begin
    int    n;
    bit    have;
    exp_t  e;
    dchk_t d;
    n = int'(i_done) + int'(d_done) + int'(a_done);
    if (n != 0) begin
      total_cnt++;
      if (n == 1) pass_cnt++;
      else $display("FAIL done_onehot: got %0d done pulses, required 1", n);
      e = '{rd: '0, err: 1'b0};
      if (i_done) begin
        have = (qi.size() != 0);
        if (have) e = qi.pop_front();
        cmp_done("I", have, e, i_rdata);
      end
      if (d_done) begin
        have = (qd.size() != 0);
        if (have) e = qd.pop_front();
        cmp_done("D", have, e, d_rdata);
      end
      if (a_done) begin
        have = (qa.size() != 0);
        if (have) e = qa.pop_front();
        cmp_done("A", have, e, a_rdata);
      end
    end
    while (dq.size() != 0) begin
      d = dq.pop_front();
      total_cnt++;
      if (d.act === d.exp) pass_cnt++;
      else $display("FAIL %s: got %0h, required %0h", d.name, d.act, d.exp);
    end
  end

  task automatic dchk(input string n, input logic [31:0] a, input logic [31:0] e);
    dq.push_back('{name: n, act: a, exp: e});
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mem_valid && !prev_mv)
      glog.push_back('{own: owner, we: mem_we, addr: mem_addr, wd: mem_wdata, cyc: cyc});
    prev_mv = mem_valid;
    if (i_done) i_req = 1'b0;
    if (d_done) d_req = 1'b0;
    if (a_done) a_req = 1'b0;
  endtask

  // who: 1 = I, 2 = D, 3 = A. Expected rdata: memory word for reads,
  // previous value for writes and aborted accesses.
  task automatic issue(input int who, input logic we, input logic [18:0] addr,
                       input logic [18:0] wd, input bit abort);
    exp_t e;
    logic wr;
    wr   = (who == 1) ? 1'b0 : we;
    e.rd = (wr || abort) ? last_rd[who] : mem_fn(addr);
    e.err = abort;
    last_rd[who] = e.rd;
    case (who)
      1: begin qi.push_back(e); i_addr = addr; i_req = 1'b1; end
      2: begin qd.push_back(e); d_we = we; d_addr = addr; d_wdata = wd; d_req = 1'b1; end
      default: begin qa.push_back(e); a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
    endcase
  endtask

  task automatic wait_clear(input logic [2:0] m, input int max, input string tag);
    int k;
    k = 0;
    while ((({a_req, d_req, i_req} & m) != 3'b000) && k < max) begin
      tick();
      k++;
    end
    dchk({tag, "_reqs_cleared"}, 32'({a_req, d_req, i_req} & m), 32'd0);
  endtask

  task automatic check_owners(input string tag, input int exp_own[$]);
    dchk({tag, "_grant_count"}, 32'(glog.size()), 32'(exp_own.size()));
    if (glog.size() == exp_own.size())
      foreach (exp_own[k])
        dchk($sformatf("%s_grant%0d", tag, k), 32'(glog[k].own), 32'(exp_own[k]));
    glog.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int   nv;
    int   k;
    logic lastmv;
    int   t3_own[$];
    for (int i = 1; i <= 3; i++) last_rd[i] = '0;

    // Reset state
    repeat (3) tick();
    dchk("rst_mem_valid", 32'(mem_valid), 0);
    dchk("rst_mem_addr",  32'({mem_we, mem_addr}), 0);
    dchk("rst_mem_wdata", 32'(mem_wdata), 0);
    dchk("rst_owner",     32'(owner), 0);
    dchk("rst_busy_err",  32'({busy, err, i_done, d_done, a_done}), 0);
    dchk("rst_rdata",     32'(i_rdata | d_rdata | a_rdata), 0);
    rst = 1'b0;
    tick();

    // 1: single zero-wait I read
    issue(1, 1'b0, 19'h00010, '0, 1'b0);
    tick();
    dchk("t1_c1_mem_valid", 32'(mem_valid), 1);
    dchk("t1_c1_owner",     32'(owner), 1);
    dchk("t1_c1_mem_addr",  32'(mem_addr), 32'h00010);
    tick();
    dchk("t1_c2_i_done",    32'(i_done), 1);
    dchk("t1_c2_owner",     32'(owner), 1);
    dchk("t1_c2_mem_valid", 32'(mem_valid), 0);
    tick();
    dchk("t1_c3_owner",     32'(owner), 0);
    dchk("t1_c3_busy",      32'(busy), 0);
    dchk("t1_c3_i_rdata",   32'(i_rdata), 32'h1ABCD);
    glog.delete();

    // 2: D write and I read arrive together
    issue(2, 1'b1, 19'h00100, 19'h05555, 1'b0);
    issue(1, 1'b0, 19'h00020, '0, 1'b0);
    wait_clear(3'b011, 20, "t2");
    dchk("t2_grant_count", 32'(glog.size()), 2);
    if (glog.size() == 2) begin
      dchk("t2_first_owner", 32'(glog[0].own), 2);
      dchk("t2_first_we",    32'(glog[0].we), 1);
      dchk("t2_first_addr",  32'(glog[0].addr), 32'h00100);
      dchk("t2_first_wdata", 32'(glog[0].wd), 32'h05555);
      dchk("t2_second_owner", 32'(glog[1].own), 1);
      dchk("t2_second_we",    32'(glog[1].we), 0);
      dchk("t2_grant_gap",    32'(glog[1].cyc - glog[0].cyc), 3);
    end
    glog.delete();

    // 3: A starves while D and I alternate, then wins on the 9th arbitration
    issue(3, 1'b0, 19'h00500, '0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      issue(2, 1'b0, 19'(19'h00300 + p), '0, 1'b0);
      issue(1, 1'b0, 19'(19'h00400 + p), '0, 1'b0);
      wait_clear((p < 4) ? 3'b011 : 3'b111, 40, $sformatf("t3_pair%0d", p));
    end
    // Starvation count must be back to 0: D beats A again.
    issue(3, 1'b0, 19'h00501, '0, 1'b0);
    issue(2, 1'b0, 19'h00310, '0, 1'b0);
    wait_clear(3'b110, 20, "t3_after");
    t3_own = '{2, 1, 2, 1, 2, 1, 2, 1, 3, 2, 1, 2, 3};
    check_owners("t3", t3_own);

    // 4: A write with 5 wait states
    wait_cycles = 5;
    issue(3, 1'b1, 19'h12345, 19'h6789A, 1'b0);
    nv = 0; k = 0; lastmv = 1'b0;
    while (a_req && k < 30) begin
      tick();
      if (a_done) dchk("t4_done_after_ready", 32'({lastmv, mem_valid}), 32'b10);
      if (mem_valid) begin
        nv++;
        dchk("t4_stable_addr",  32'(mem_addr), 32'h12345);
        dchk("t4_stable_we",    32'(mem_we), 1);
        dchk("t4_stable_wdata", 32'(mem_wdata), 32'h6789A);
      end
      lastmv = mem_valid;
      k++;
    end
    dchk("t4_busy_cycles", 32'(nv), 6);
    dchk("t4_a_req_cleared", 32'(a_req), 0);
    wait_cycles = 0;
    glog.delete();

    // 5: memory never answers -> abort after 64 BUSY cycles
    wait_cycles = -1;
    issue(2, 1'b0, 19'h00200, '0, 1'b1);
    nv = 0; k = 0;
    while (d_req && k < 100) begin
      tick();
      if (mem_valid) nv++;
      k++;
    end
    dchk("t5_busy_cycles", 32'(nv), 64);
    dchk("t5_d_req_cleared", 32'(d_req), 0);
    wait_cycles = 0;
    issue(2, 1'b0, 19'h00201, '0, 1'b0);
    wait_clear(3'b010, 10, "t5_next");
    glog.delete();

    // 6: reset during BUSY drops the transaction without a done pulse
    wait_cycles = -1;
    tick();
    i_addr = 19'h00777;
    i_req  = 1'b1;
    repeat (3) tick();
    dchk("t6_busy_before_rst", 32'({busy, mem_valid}), 32'b11);
    rst   = 1'b1;
    i_req = 1'b0;
    tick();
    dchk("t6_rst_mem_valid", 32'(mem_valid), 0);
    dchk("t6_rst_owner",     32'(owner), 0);
    dchk("t6_rst_busy",      32'(busy), 0);
    dchk("t6_rst_rdata",     32'(i_rdata | d_rdata | a_rdata), 0);
    for (int i = 1; i <= 3; i++) last_rd[i] = '0;
    rst = 1'b0;
    wait_cycles = 0;
    tick();
    issue(1, 1'b0, 19'h00010, '0, 1'b0);
    wait_clear(3'b001, 10, "t6_fresh");
    tick();
    dchk("t6_fresh_i_rdata", 32'(i_rdata), 32'h1ABCD);

    // Every issued transaction must have completed.
    dchk("end_qi_empty", 32'(qi.size()), 0);
    dchk("end_qd_empty", 32'(qd.size()), 0);
    dchk("end_qa_empty", 32'(qa.size()), 0);
    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single 19-bit-address / 19-bit-data memory port between three requesters: instruction fetch (I), core load/store (D) and the FFT/crypto accelerator DMA (A). Fixed priority D > I > A, with an ageing override so A cannot starve. Sits between the pipeline's fetch and memory stages, the accelerator, and the memory controller. One transaction is outstanding at a time; wait-stated memory and timeout are handled here.

Parameters:
AW, 19, address width
DW, 19, data width
STARVE_LIMIT, 8, lost arbitrations before A is promoted to top priority
TIMEOUT, 64, BUSY cycles without mem_ready before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req  in  1  fetch request, held until i_done
i_addr  in  AW  fetch address, stable while i_req
i_rdata  out  DW  fetched word, valid with i_done, held until next I completion
i_done  out  1  one-cycle completion pulse
d_req, a_req  in  1  data / DMA request, held until *_done
d_we, a_we  in  1  1 = write
d_addr, a_addr  in  AW  address
d_wdata, a_wdata  in  DW  write data
d_rdata, a_rdata  out  DW  read data, same rules as i_rdata
d_done, a_done  out  1  completion pulse
err  out  1  high with the *_done pulse of a timed-out transaction
mem_valid  out  1  memory request
mem_we  out  1  write enable
mem_addr  out  AW  address
mem_wdata  out  DW  write data
mem_rdata  in  DW  read data, valid when mem_ready
mem_ready  in  1  memory accepts/completes the request this cycle
owner  out  2  0 none, 1 I, 2 D, 3 A; current grant
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, starvation counter 0, timeout counter 0. A reset mid-transaction drops it with no done pulse; memory is reset in the same cycle.
- FSM IDLE -> BUSY -> RESP -> IDLE.
- IDLE: if any req, pick a winner and register mem_valid=1, plus mem_we/addr/wdata (we/wdata 0 for I), and owner. Then go to BUSY. No req means stay in IDLE.
- Priority: D > I > A. If starve_cnt == STARVE_LIMIT and a_req, A wins over all.
- starve_cnt: +1 on each IDLE arbitration where a_req=1 and A loses, saturating at STARVE_LIMIT. Cleared when A is granted.
- BUSY: mem_* held stable. On mem_ready: mem_valid to 0, capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), go to RESP. Timeout counter +1 per BUSY cycle without mem_ready. On reaching TIMEOUT: mem_valid to 0, rdata unchanged, err set, go to RESP.
- RESP: owner's *_done=1 (err=1 if aborted) for exactly this cycle. All reqs are ignored. Then go to IDLE with owner=0 and timeout counter cleared.
- Requesters deassert req on the clock edge where they see done. A req still high in the following IDLE cycle is treated as a new transaction.
- Latency: req seen in IDLE cycle 0 gives mem_valid in cycle 1. With mem_ready in cycle 1 (zero wait), done is in cycle 2. Back-to-back throughput is one transaction per 3 cycles plus memory wait states.
- Simultaneous I and D requests: D is served first. I stays pending, and starve_cnt is untouched unless A is also requesting.
- Only one *_done is ever high in a cycle.
- req dropped while granted is protocol misuse: the transaction still completes and done still pulses.

Test Plan:
1. Reset, then I read addr 0x00010 with mem_ready same cycle and mem_rdata 0x1ABCD -> mem_valid cycle 1, i_done cycle 2, i_rdata 0x1ABCD, owner sequence 1,1,0.
2. I and D requesting in the same IDLE cycle; D write 0x00100 <- 0x05555 -> D granted first (mem_we=1, d_done, d_rdata unchanged); I is then granted at the next IDLE, 3 cycles later.
3. A requesting continuously while D and I alternate on every IDLE -> A granted after exactly 8 lost arbitrations; starve_cnt returns to 0.
4. mem_ready delayed 5 cycles -> mem_addr/we/wdata stable for all 6 BUSY cycles; done arrives 1 cycle after mem_ready; err=0.
5. mem_ready never asserted -> abort after 64 BUSY cycles; done+err pulse for one cycle; rdata keeps its previous value; next request proceeds normally.
6. rst asserted during BUSY -> next cycle mem_valid=0, owner=0, busy=0, no done pulse; a fresh I request then completes normally.
